// File: rtl/gpu_pkg.sv
// gpu_pkg: shared opcodes, screen geometry defaults and state encodings for the text controller
package gpu_pkg;
   localparam int COLS_DEF = 40;
   localparam int ROWS_DEF = 25;
   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_MODE = 8'hC0;
   localparam logic [7:0] OP_PUTC = 8'hC1;
   localparam logic [7:0] OP_BS   = 8'hC2;
   localparam logic [7:0] OP_SETY = 8'hC3;
   localparam logic [7:0] OP_SETX = 8'hC4;
   localparam logic [7:0] OP_CLS  = 8'hC5;
   localparam logic [7:0] OP_NL   = 8'hC6;
   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_CLEAR} state_t;
   typedef enum logic [2:0] {CUR_NONE, CUR_ADV, CUR_RET, CUR_NL, CUR_SETX, CUR_SETY, CUR_HOME} cur_op_t;
endpackage

// File: rtl/gpu_cursor.sv
// gpu_cursor: text cursor x/y registers, movement rules and linear cell pointer
module gpu_cursor
   import gpu_pkg::*;
#(
   parameter int COLS   = COLS_DEF,
   parameter int ROWS   = ROWS_DEF,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_i,
   input  cur_op_t           op_i,
   input  logic [15:0]       param_i,
   output logic [5:0]        x_o,
   output logic [4:0]        y_o,
   output logic [ADDR_W-1:0] ptr_o
);
   logic [5:0] x_q, x_d;
   logic [4:0] y_q, y_d;
   logic last_x, last_y;
   logic [ADDR_W-1:0] y_w;
   assign last_x = x_q == 6'(COLS - 1);
   assign last_y = y_q == 5'(ROWS - 1);
   assign y_w    = ADDR_W'(y_q);
   // y*40 + x as y*32 + y*8 + x; clamped x/y keep this below CELLS
   assign ptr_o  = (y_w << 5) + (y_w << 3) + ADDR_W'(x_q);
   assign x_o    = x_q;
   assign y_o    = y_q;
   // next cursor position for the requested movement
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      case (op_i)
         CUR_ADV: begin
            x_d = last_x ? '0 : x_q + 6'd1;
            y_d = !last_x ? y_q : last_y ? '0 : y_q + 5'd1;
         end
         CUR_RET: begin
            x_d = x_q == '0 ? 6'(COLS - 1) : x_q - 6'd1;
            y_d = x_q == '0 ? y_q - 5'd1 : y_q;
         end
         CUR_NL: begin
            x_d = '0;
            y_d = last_y ? '0 : y_q + 5'd1;
         end
         CUR_SETX: x_d = param_i > 16'(COLS - 1) ? 6'(COLS - 1) : param_i[5:0];
         CUR_SETY: y_d = param_i > 16'(ROWS - 1) ? 5'(ROWS - 1) : param_i[4:0];
         CUR_HOME: begin
            x_d = '0;
            y_d = '0;
         end
         default: ;
      endcase
   end
   // cursor registers, homed on reset
   always_ff @(posedge clk) begin
      if (rst_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
endmodule

// File: rtl/gpu_text_ctrl.sv
// gpu_text_ctrl: command sequencer for the text buffer, arbitrating the RAM with display fetch first
module gpu_text_ctrl
   import gpu_pkg::*;
#(
   parameter int COLS   = COLS_DEF,
   parameter int ROWS   = ROWS_DEF,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_op,
   input  logic [15:0]       cmd_param,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [7:0]        disp_data,
   output logic              disp_valid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [5:0]        cursor_x,
   output logic [4:0]        cursor_y,
   output logic              busy
);
   localparam int CELLS = COLS * ROWS;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);
   state_t state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, clr_addr_q, clr_addr_d, ptr;
   logic [7:0] wr_data_q, wr_data_d;
   logic bs_q, bs_d, disp_valid_q;
   logic accept, op_clear, op_write, at_home, pend;
   cur_op_t cur_op;
   assign accept   = cmd_valid & cmd_ready;
   assign op_clear = cmd_op == OP_CLS || (cmd_op == OP_MODE && cmd_param == '0);
   assign at_home  = cursor_x == '0 && cursor_y == '0;
   // backspace at home has nothing to erase, so it never enters WRITE
   assign op_write = cmd_op == OP_PUTC || (cmd_op == OP_BS && !at_home);
   assign pend     = state_q != ST_IDLE;
   gpu_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
      .clk     (clk),
      .rst_i   (clr),
      .op_i    (cur_op),
      .param_i (cmd_param),
      .x_o     (cursor_x),
      .y_o     (cursor_y),
      .ptr_o   (ptr)
   );
   // state register; reset aborts any write or clear immediately
   always_ff @(posedge clk) begin
      state_q <= clr ? ST_IDLE : state_d;
   end
   // next state: pending cells only retire in cycles the display leaves the RAM free
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = !accept ? ST_IDLE : op_clear ? ST_CLEAR : op_write ? ST_WRITE : ST_IDLE;
         ST_WRITE: if (!disp_req) state_d = ST_IDLE;
         ST_CLEAR: if (!disp_req && clr_addr_q == LAST) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end
   // captured write target/data and the clear sweep address
   always_comb begin
      wr_addr_d  = accept ? (cmd_op == OP_BS ? ptr - ADDR_W'(1) : ptr) : wr_addr_q;
      wr_data_d  = accept ? (cmd_op == OP_PUTC ? cmd_param[7:0] : 8'h00) : wr_data_q;
      bs_d       = accept ? cmd_op == OP_BS : bs_q;
      clr_addr_d = state_q != ST_CLEAR ? '0 : disp_req ? clr_addr_q : clr_addr_q + ADDR_W'(1);
   end
   // datapath registers and the one-cycle display read tracker
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         bs_q         <= 1'b0;
         clr_addr_q   <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         bs_q         <= bs_d;
         clr_addr_q   <= clr_addr_d;
         disp_valid_q <= disp_req;
      end
   end
   // outputs: RAM arbitration, handshake, and cursor movement requests
   always_comb begin
      cmd_ready  = !clr && state_q == ST_IDLE;
      busy       = !clr && state_q == ST_CLEAR;
      ram_en     = !clr && (disp_req || pend);
      ram_we     = !clr && !disp_req && pend;
      ram_addr   = !ram_en ? '0 : disp_req ? disp_addr : state_q == ST_CLEAR ? clr_addr_q : wr_addr_q;
      ram_wdata  = ram_we && state_q == ST_WRITE ? wr_data_q : 8'h00;
      disp_valid = disp_valid_q;
      disp_data  = disp_valid_q ? ram_rdata : 8'h00;
      cur_op     = state_q == ST_WRITE ? (disp_req ? CUR_NONE : bs_q ? CUR_RET : CUR_ADV)
                 : !accept ? CUR_NONE
                 : op_clear ? CUR_HOME
                 : cmd_op == OP_SETX ? CUR_SETX
                 : cmd_op == OP_SETY ? CUR_SETY
                 : cmd_op == OP_NL ? CUR_NL
                 : CUR_NONE;
   end
endmodule

// File: tb/tb_gpu_text_ctrl.sv
// tb_gpu_text_ctrl: directed checks of commands, arbitration, clear and reset abort
module tb_gpu_text_ctrl;
   logic clk = 1'b0;
   logic clr, cmd_valid, disp_req;
   logic [7:0] cmd_op;
   logic [15:0] cmd_param;
   logic [9:0] disp_addr;
   logic cmd_ready, disp_valid, ram_en, ram_we, busy;
   logic [7:0] disp_data, ram_wdata, ram_rdata;
   logic [9:0] ram_addr;
   logic [5:0] cursor_x;
   logic [4:0] cursor_y;
   logic [7:0] mem [1000];
   int n_assert = 0, n_fail = 0;
   int wr_cnt = 0, clr_next = 0, order_err = 0;
   bit clr_mon = 1'b0;

   always #5 clk = ~clk;

   gpu_text_ctrl dut (
      .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_param(cmd_param), .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_data(disp_data), .disp_valid(disp_valid), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
   );

   // single-port RAM model with one-cycle read latency
   always @(posedge clk) begin
      if (ram_en && ram_addr < 10'd1000) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end
   end

   // write tracker, including ascending-order tracking during a clear sweep
   always @(negedge clk) begin
      if (ram_en && ram_we) begin
         wr_cnt++;
         if (clr_mon) begin
            if (ram_addr !== 10'(clr_next) || ram_wdata !== 8'h00) order_err++;
            clr_next++;
         end
      end
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task send(input logic [7:0] op, input logic [15:0] p);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_param = p;
      tick;
      cmd_valid = 1'b0;
      #1;
   endtask

   task putc_at(input logic [15:0] y, input logic [15:0] x, input logic [7:0] d);
      send(8'hC3, y);
      send(8'hC4, x);
      send(8'hC1, {8'h00, d});
      tick;
   endtask

   task test_reset;
      clr = 1'b1; cmd_valid = 1'b0; cmd_op = 8'h00; cmd_param = 16'h0;
      disp_req = 1'b1; disp_addr = 10'd0;
      tick; tick;
      n_assert++; if (cmd_ready !== 1'b0 || ram_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold: ready=%b ram_en=%b busy=%b want 0 0 0", cmd_ready, ram_en, busy); end
      disp_req = 1'b0;
      tick;
      n_assert++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || disp_valid !== 1'b0 || disp_data !== 8'h00 || ram_we !== 1'b0 || ram_addr !== 10'd0 || ram_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: x=%0d y=%0d dv=%b dd=%h we=%b addr=%0d wd=%h want all 0", cursor_x, cursor_y, disp_valid, disp_data, ram_we, ram_addr, ram_wdata); end
      clr = 1'b0;
      #1;
      n_assert++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
      tick;
   endtask

   task test_putc;
      int w0;
      w0 = wr_cnt;
      send(8'hC1, 16'h0041);
      n_assert++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'd0 || ram_wdata !== 8'h41 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL putc_write: en=%b we=%b addr=%0d data=%h ready=%b want 1 1 0 41 0", ram_en, ram_we, ram_addr, ram_wdata, cmd_ready); end
      tick;
      n_assert++; if (cmd_ready !== 1'b1 || cursor_x !== 6'd1 || cursor_y !== 5'd0 || ram_en !== 1'b0 || wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL putc_after: ready=%b x=%0d y=%0d en=%b writes=%0d want 1 1 0 0 1", cmd_ready, cursor_x, cursor_y, ram_en, wr_cnt - w0); end
   endtask

   task test_wrap;
      send(8'hC3, 16'd24);
      n_assert++; if (cursor_y !== 5'd24 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL sety: y=%0d ready=%b want 24 1", cursor_y, cmd_ready); end
      send(8'hC4, 16'd39);
      send(8'hC1, 16'h005A);
      n_assert++; if (ram_we !== 1'b1 || ram_addr !== 10'd999 || ram_wdata !== 8'h5A) begin n_fail++; $display("FAIL putc_last_cell: we=%b addr=%0d data=%h want 1 999 5a", ram_we, ram_addr, ram_wdata); end
      tick;
      n_assert++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0) begin n_fail++; $display("FAIL putc_wrap: x=%0d y=%0d want 0 0", cursor_x, cursor_y); end
      send(8'hC4, 16'd60);
      n_assert++; if (cursor_x !== 6'd39) begin n_fail++; $display("FAIL setx_clamp: x=%0d want 39", cursor_x); end
      send(8'hC3, 16'd300);
      n_assert++; if (cursor_y !== 5'd24) begin n_fail++; $display("FAIL sety_clamp: y=%0d want 24", cursor_y); end
   endtask

   task test_backspace;
      int w0;
      send(8'hC4, 16'd0);
      send(8'hC3, 16'd3);
      send(8'hC2, 16'd0);
      n_assert++; if (ram_we !== 1'b1 || ram_addr !== 10'd119 || ram_wdata !== 8'h00) begin n_fail++; $display("FAIL bs_write: we=%b addr=%0d data=%h want 1 119 00", ram_we, ram_addr, ram_wdata); end
      tick;
      n_assert++; if (cursor_x !== 6'd39 || cursor_y !== 5'd2 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bs_cursor: x=%0d y=%0d ready=%b want 39 2 1", cursor_x, cursor_y, cmd_ready); end
      send(8'hC3, 16'd0);
      send(8'hC4, 16'd0);
      w0 = wr_cnt;
      send(8'hC2, 16'd0);
      tick;
      n_assert++; if (ram_en !== 1'b0 || cmd_ready !== 1'b1 || cursor_x !== 6'd0 || cursor_y !== 5'd0 || wr_cnt !== w0) begin n_fail++; $display("FAIL bs_home: en=%b ready=%b x=%0d y=%0d writes=%0d want 0 1 0 0 0", ram_en, cmd_ready, cursor_x, cursor_y, wr_cnt - w0); end
   endtask

   task test_back_to_back;
      int w0;
      w0 = wr_cnt;
      cmd_valid = 1'b1; cmd_op = 8'hC3; cmd_param = 16'd5;
      tick;
      n_assert++; if (cmd_ready !== 1'b1 || cursor_y !== 5'd5) begin n_fail++; $display("FAIL b2b_1: ready=%b y=%0d want 1 5", cmd_ready, cursor_y); end
      cmd_op = 8'hC4; cmd_param = 16'd7;
      tick;
      n_assert++; if (cmd_ready !== 1'b1 || cursor_x !== 6'd7) begin n_fail++; $display("FAIL b2b_2: ready=%b x=%0d want 1 7", cmd_ready, cursor_x); end
      cmd_op = 8'hC6; cmd_param = 16'd0;
      tick;
      cmd_valid = 1'b0;
      #1;
      n_assert++; if (cursor_x !== 6'd0 || cursor_y !== 5'd6) begin n_fail++; $display("FAIL b2b_newline: x=%0d y=%0d want 0 6", cursor_x, cursor_y); end
      send(8'hC3, 16'd24);
      send(8'hC6, 16'd0);
      n_assert++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0) begin n_fail++; $display("FAIL newline_wrap: x=%0d y=%0d want 0 0", cursor_x, cursor_y); end
      send(8'hC0, 16'd5);
      send(8'hC7, 16'd1);
      send(8'h00, 16'd0);
      n_assert++; if (ram_en !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || wr_cnt !== w0) begin n_fail++; $display("FAIL ignored_ops: en=%b busy=%b ready=%b writes=%0d want 0 0 1 0", ram_en, busy, cmd_ready, wr_cnt - w0); end
   endtask

   task test_putc_stall;
      int bad;
      bad = 0;
      disp_req = 1'b1; disp_addr = 10'd0;
      send(8'hC1, 16'h0033);
      n_assert++; if (disp_valid !== 1'b1 || disp_data !== 8'h41) begin n_fail++; $display("FAIL disp_read: valid=%b data=%h want 1 41", disp_valid, disp_data); end
      for (int i = 0; i < 5; i++) begin
         if (ram_en !== 1'b1 || ram_we !== 1'b0 || cmd_ready !== 1'b0 || ram_addr !== 10'd0) bad++;
         tick;
      end
      n_assert++; if (bad !== 0) begin n_fail++; $display("FAIL stall_cycles: bad=%0d want 0", bad); end
      disp_req = 1'b0;
      #1;
      n_assert++; if (ram_we !== 1'b1 || ram_addr !== 10'd0 || ram_wdata !== 8'h33 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_write: we=%b addr=%0d data=%h ready=%b want 1 0 33 0", ram_we, ram_addr, ram_wdata, cmd_ready); end
      tick;
      n_assert++; if (cmd_ready !== 1'b1 || cursor_x !== 6'd1 || disp_valid !== 1'b0 || mem[0] !== 8'h33) begin n_fail++; $display("FAIL stall_after: ready=%b x=%0d dv=%b mem0=%h want 1 1 0 33", cmd_ready, cursor_x, disp_valid, mem[0]); end
   endtask

   task test_clear;
      int w0, busy_cnt, stall_cnt, vbad, nz;
      bit prev_req, done;
      w0 = wr_cnt; busy_cnt = 0; stall_cnt = 0; vbad = 0; nz = 0; done = 1'b0;
      clr_next = 0; order_err = 0; clr_mon = 1'b1;
      disp_req = 1'b0;
      send(8'hC5, 16'd0);
      n_assert++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL clear_start: x=%0d y=%0d busy=%b ready=%b want 0 0 1 0", cursor_x, cursor_y, busy, cmd_ready); end
      prev_req = 1'b0;
      for (int n = 0; n < 3000 && !done; n++) begin
         disp_req = n[0];
         disp_addr = 10'(n % 1000);
         #1;
         if (disp_valid !== prev_req) vbad++;
         if (busy) begin
            busy_cnt++;
            if (disp_req) stall_cnt++;
            prev_req = disp_req;
            tick;
         end else done = 1'b1;
      end
      disp_req = 1'b0;
      clr_mon = 1'b0;
      n_assert++; if (!done) begin n_fail++; $display("FAIL clear_timeout: busy still %b after 3000 cycles", busy); end
      n_assert++; if (busy_cnt !== 1000 + stall_cnt) begin n_fail++; $display("FAIL clear_busy_len: got %0d want %0d", busy_cnt, 1000 + stall_cnt); end
      n_assert++; if (wr_cnt - w0 !== 1000 || clr_next !== 1000 || order_err !== 0) begin n_fail++; $display("FAIL clear_writes: writes=%0d seen=%0d order_err=%0d want 1000 1000 0", wr_cnt - w0, clr_next, order_err); end
      n_assert++; if (vbad !== 0) begin n_fail++; $display("FAIL clear_disp_valid: bad=%0d want 0", vbad); end
      tick;
      for (int a = 0; a < 1000; a++) if (mem[a] !== 8'h00) nz++;
      n_assert++; if (nz !== 0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL clear_contents: nonzero=%0d ready=%b want 0 1", nz, cmd_ready); end
   endtask

   task test_clear_abort;
      disp_req = 1'b0;
      putc_at(16'd12, 16'd19, 8'h11);
      putc_at(16'd12, 16'd20, 8'hAA);
      putc_at(16'd17, 16'd20, 8'hCC);
      putc_at(16'd24, 16'd39, 8'hBB);
      send(8'hC5, 16'd0);
      for (int i = 0; i < 500; i++) tick;
      n_assert++; if (ram_we !== 1'b1 || ram_addr !== 10'd500) begin n_fail++; $display("FAIL abort_pos: we=%b addr=%0d want 1 500", ram_we, ram_addr); end
      clr = 1'b1;
      #1;
      n_assert++; if (ram_en !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL abort_clr_cycle: en=%b ready=%b want 0 0", ram_en, cmd_ready); end
      tick;
      clr = 1'b0;
      #1;
      n_assert++; if (ram_en !== 1'b0 || busy !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_after: en=%b busy=%b x=%0d y=%0d ready=%b want 0 0 0 0 1", ram_en, busy, cursor_x, cursor_y, cmd_ready); end
      tick; tick;
      n_assert++; if (mem[499] !== 8'h00 || mem[500] !== 8'hAA || mem[700] !== 8'hCC || mem[999] !== 8'hBB || ram_en !== 1'b0) begin n_fail++; $display("FAIL abort_contents: m499=%h m500=%h m700=%h m999=%h en=%b want 00 aa cc bb 0", mem[499], mem[500], mem[700], mem[999], ram_en); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_putc;
      test_wrap;
      test_backspace;
      test_back_to_back;
      test_putc_stall;
      test_clear;
      test_clear_abort;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
